sata_fis_rx_dispatcher: RTL
===========================

# sata_fis_rx_dispatcher

Transport-layer receive dispatcher. It takes the serial stream of received FIS frames from the link layer and decodes the FIS type from the first dword of each frame. It then steers the whole frame, unchanged, to one of two downstream streaming ports: the register/PIO-setup FIS receiver or the data FIS sink. DMA Activate frames become a single pulse, and any other type is consumed and counted as dropped.

## Interface

Parameters:
- DROP_CNT_W, 16, width of saturating dropped-frame counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_dat  input  32  received frame dword
- i_val  input  1  i_dat valid
- i_eop  input  1  last dword of frame
- i_err  input  1  frame CRC/link error, meaningful with i_eop
- i_rdy  output  1  dispatcher accepts current dword
- o_reg_dat  output  32  register-port dword
- o_reg_val / o_reg_eop / o_reg_err  output  1 each  register-port valid/eop/err
- o_reg_rdy  input  1  register-port ready
- o_dat_dat  output  32  data-port dword
- o_dat_val / o_dat_eop / o_dat_err  output  1 each  data-port valid/eop/err
- o_dat_rdy  input  1  data-port ready
- o_dmaact  output  1  one-cycle pulse per valid DMA Activate FIS
- o_type  output  8  type byte of last started frame
- o_drop_cnt  output  DROP_CNT_W  saturating count of discarded frames

## Operation

- Transfer occurs when i_val & i_rdy.
- Type decode uses i_dat[7:0] of the first dword:
  - 0x34 (Register D2H), 0x5F (PIO Setup), 0xA1 (Set Device Bits) → REG
  - 0x46 (Data) → DAT
  - 0x39 (DMA Activate) → DMA
  - anything else → DROP
- State machine: IDLE, REG, DAT, DROP.
  - IDLE: destination comes from the combinational decode of i_dat.
  - Other states: destination is the registered state.
- Transitions:
  - IDLE, transfer with i_eop=0: go to REG/DAT/DROP per decode. DMA without eop also goes to DROP.
  - IDLE, transfer with i_eop=1: single-dword frame, stay IDLE.
  - REG/DAT/DROP, transfer with i_eop=1: go to IDLE.
  - Any other case: hold state.
- Data path is pass-through and combinational:
  - o_x_dat = i_dat, o_x_eop = i_eop, o_x_err = i_err.
  - o_x_val = i_val & (destination==x).
  - i_rdy = o_reg_rdy when destination is REG, o_dat_rdy when destination is DAT, 1 for DMA or DROP.
  - Non-selected port val is 0. Its dat/eop/err are don't-care.
- o_type loads i_dat[7:0] on every frame-start transfer (IDLE & transfer).
- o_dmaact pulses for 1 cycle, the cycle after a transfer in IDLE with type 0x39, i_eop=1, i_err=0.
- o_drop_cnt increments by 1 on the end of each discarded frame, and saturates at all-ones. Discarded frames are:
  - a DROP-type frame (counted on its eop transfer)
  - a DMA Activate with i_err=1
  - a DMA Activate longer than 1 dword (counted on its eop)
- Frames with i_err are otherwise forwarded unchanged. Downstream receivers judge CRC.

## Timing

- Reset values:
  - state IDLE
  - o_dmaact 0, o_type 0x00, o_drop_cnt 0
  - registered outputs are async-cleared
  - combinational outputs follow the inputs in IDLE
- Data-path latency is 0 cycles. o_dmaact and o_drop_cnt latency is 1 cycle after the eop transfer.
- No buffering. Backpressure from the selected port propagates combinationally to i_rdy. A stalled word is held by upstream, and the dispatcher re-decodes it every cycle while in IDLE.
- Back-to-back frames: the eop transfer of one frame and the first dword of the next in the following cycle are both accepted with no bubble.
- Reset mid-frame: the dispatcher returns to IDLE. The next valid dword is treated as a frame start, so upstream must be reset together with it.
- i_val=0 cycles inside a frame hold state and produce no output valids.

## Test plan

- Register D2H, 5 dwords, first 0x00500034, o_reg_rdy=1:
  - all 5 dwords appear on the reg port with o_reg_eop on dword 5
  - o_dat_val stays 0, o_type=0x34, state returns to IDLE
- Data FIS 0x00000046 plus 3 dwords, with o_dat_rdy low for 2 cycles on dword 2:
  - i_rdy=0 for those 2 cycles
  - dword 2 is delivered once, with no duplication or loss
- Single dword 0x00000039 with eop, err=0: o_dmaact=1 for exactly one cycle, next cycle; no port valids.
- Same DMA Activate with err=1: no pulse, o_drop_cnt 0→1.
- Unknown type 0x41 (DMA Setup), 7 dwords, while both port rdys are 0:
  - i_rdy=1 throughout
  - o_drop_cnt +1 after the eop transfer
- Back-to-back REG(5) then DAT(2) frames with no gap: correct port steering and zero bubble.
- reset_n asserted at dword 3 of a REG frame: outputs return to reset values immediately, and the next frame routes correctly.
- Drop counter preset near all-ones (DROP_CNT_W=2, 4 dropped frames): counter saturates at 3.

Source files
------------

// File: rtl/sata_fis_rx_dispatcher.sv
// Transport-layer receive dispatcher: decodes the FIS type from the first dword of each frame and steers
// the frame to the register or data port, turns DMA Activate into a pulse, and counts discarded frames.
module sata_fis_rx_dispatcher #(
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           i_dat,
    input  logic                  i_val,
    input  logic                  i_eop,
    input  logic                  i_err,
    output logic                  i_rdy,
    output logic [31:0]           o_reg_dat,
    output logic                  o_reg_val,
    output logic                  o_reg_eop,
    output logic                  o_reg_err,
    input  logic                  o_reg_rdy,
    output logic [31:0]           o_dat_dat,
    output logic                  o_dat_val,
    output logic                  o_dat_eop,
    output logic                  o_dat_err,
    input  logic                  o_dat_rdy,
    output logic                  o_dmaact,
    output logic [7:0]            o_type,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam logic [7:0] FIS_REG_D2H = 8'h34;
    localparam logic [7:0] FIS_PIO_SET = 8'h5F;
    localparam logic [7:0] FIS_SDB     = 8'hA1;
    localparam logic [7:0] FIS_DATA    = 8'h46;
    localparam logic [7:0] FIS_DMA_ACT = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REG,
        ST_DAT,
        ST_DROP
    } state_t;

    typedef enum logic [1:0] {
        DST_REG,
        DST_DAT,
        DST_DMA,
        DST_DROP
    } dest_t;

    state_t state;
    state_t state_nx;
    dest_t  dest_dec;
    dest_t  dest;
    logic   xfer;
    logic   frame_start;
    logic   drop_end;
    logic   dmaact_set;

    // Type decode of the word currently presented (only meaningful as a frame start)
    always_comb begin
        dest_dec = DST_DROP;
        case (i_dat[7:0])
            FIS_REG_D2H, FIS_PIO_SET, FIS_SDB: dest_dec = DST_REG;
            FIS_DATA:                          dest_dec = DST_DAT;
            FIS_DMA_ACT:                       dest_dec = DST_DMA;
            default:                           dest_dec = DST_DROP;
        endcase
    end

    // In IDLE the word is re-decoded every cycle; mid-frame the registered state decides
    always_comb begin
        dest = DST_DROP;
        case (state)
            ST_IDLE: dest = dest_dec;
            ST_REG:  dest = DST_REG;
            ST_DAT:  dest = DST_DAT;
            default: dest = DST_DROP;
        endcase
    end

    always_comb begin
        i_rdy = 1'b1;
        case (dest)
            DST_REG: i_rdy = o_reg_rdy;
            DST_DAT: i_rdy = o_dat_rdy;
            default: i_rdy = 1'b1;
        endcase
    end

    assign xfer        = i_val & i_rdy;
    assign frame_start = xfer & (state == ST_IDLE);

    assign o_reg_dat = i_dat;
    assign o_reg_eop = i_eop;
    assign o_reg_err = i_err;
    assign o_reg_val = i_val & (dest == DST_REG);
    assign o_dat_dat = i_dat;
    assign o_dat_eop = i_eop;
    assign o_dat_err = i_err;
    assign o_dat_val = i_val & (dest == DST_DAT);

    // A multi-dword DMA Activate is malformed and is drained as a dropped frame
    assign drop_end   = xfer & i_eop &
                        ((state == ST_DROP) |
                         ((state == ST_IDLE) &
                          ((dest_dec == DST_DROP) | ((dest_dec == DST_DMA) & i_err))));
    assign dmaact_set = frame_start & i_eop & ~i_err & (dest_dec == DST_DMA);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (xfer && !i_eop) begin
                    case (dest_dec)
                        DST_REG: state_nx = ST_REG;
                        DST_DAT: state_nx = ST_DAT;
                        default: state_nx = ST_DROP;
                    endcase
                end
            end
            default: begin
                if (xfer && i_eop) state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Status registers: DMA pulse, last frame type, saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_dmaact   <= 1'b0;
            o_type     <= 8'h00;
            o_drop_cnt <= '0;
        end else begin
            o_dmaact <= dmaact_set;
            if (frame_start) o_type <= i_dat[7:0];
            if (drop_end && (o_drop_cnt != {DROP_CNT_W{1'b1}}))
                o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule
